// File: rtl/motorb_act_stream_pkg.sv
// Shared types and defaults for the motorb activation stream block.
package motorb_act_stream_pkg;

  localparam int W_DEF       = 32;
  localparam int I_DEF       = 8;
  localparam int N_CH_DEF    = 9;
  localparam int LEAK_SH_DEF = 3;

  typedef enum logic [1:0] {
    MODE_RELU   = 2'd0,
    MODE_LEAKY  = 2'd1,
    MODE_CLIP   = 2'd2,
    MODE_BYPASS = 2'd3
  } act_mode_e;

  // Channel index width; never narrower than one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/motorb_act_stream_if.sv
// Sample stream in/out handshake bundle: slave is the block, master its environment.
interface motorb_act_stream_if #(
  parameter int W    = motorb_act_stream_pkg::W_DEF,
  parameter int N_CH = motorb_act_stream_pkg::N_CH_DEF
);

  localparam int CW = motorb_act_stream_pkg::chan_w(N_CH);

  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic [CW-1:0] m_chan;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_chan
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_chan
  );

endinterface

// File: rtl/motorb_act_func.sv
// Per-sample activation transfer function (ReLU / leaky / clipped / bypass).
module motorb_act_func
  import motorb_act_stream_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int LEAK_SH = LEAK_SH_DEF
) (
  input  logic signed [W-1:0] x,
  input  act_mode_e           mode,
  input  logic signed [W-1:0] clip,
  output logic signed [W-1:0] y
);

  logic                x_pos;
  logic signed [W-1:0] pos_v;
  logic signed [W-1:0] ceil_v;

  assign x_pos  = !x[W-1] && (x != '0);
  assign pos_v  = x_pos ? x : '0;
  assign ceil_v = clip[W-1] ? '0 : clip;

  always_comb begin
    // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
    y = x;
    case (mode)
      MODE_RELU:   y = pos_v;
      MODE_LEAKY:  y = x_pos ? x : (x >>> LEAK_SH);
      MODE_CLIP:   y = (pos_v > ceil_v) ? ceil_v : pos_v;
      MODE_BYPASS: y = x;
      default:     y = x;
    endcase
  end

endmodule

// File: rtl/motorb_act_stream.sv
// Two-stage activation pipeline with per-frame config latch, channel tracking and frame stats.
module motorb_act_stream
  import motorb_act_stream_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int I       = I_DEF,
  parameter int N_CH    = N_CH_DEF,
  parameter int LEAK_SH = LEAK_SH_DEF
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [1:0]          cfg_mode,
  input  logic [W-1:0]        cfg_clip,
  motorb_act_stream_if.slave  io,
  output logic                frame_done,
  output logic                err_len,
  output logic [15:0]         frame_cnt
);

  localparam int            CW      = chan_w(N_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  if (N_CH < 2 || I < 1 || I > W) begin : g_param_check
    $error("motorb_act_stream: needs N_CH >= 2 and 1 <= I <= W");
  end

  logic en, s_fire, m_fire;

  logic [CW-1:0] chan_q, chan_d;
  act_mode_e     mode_q, mode_d;
  logic [W-1:0]  clip_q, clip_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;

  logic                s1_valid_q, s1_last_q;
  logic signed [W-1:0] s1_data_q, s1_clip_q;
  logic [CW-1:0]       s1_chan_q;
  act_mode_e           s1_mode_q;

  logic                m_valid_q, m_last_q;
  logic [W-1:0]        m_data_q;
  logic [CW-1:0]       m_chan_q;
  logic signed [W-1:0] y;

  // Whole pipeline advances together; a stalled output freezes both stages.
  assign en         = !m_valid_q || io.m_ready;
  assign io.s_ready = en && ap_rst_n;
  assign s_fire     = io.s_valid && io.s_ready;
  assign m_fire     = m_valid_q && io.m_ready;

  assign io.m_valid = m_valid_q;
  assign io.m_data  = m_data_q;
  assign io.m_last  = m_last_q;
  assign io.m_chan  = m_chan_q;
  assign frame_done = m_fire && m_last_q;
  assign err_len    = err_q;
  assign frame_cnt  = cnt_q;

  always_comb begin
    chan_d = chan_q;
    mode_d = mode_q;
    clip_d = clip_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (s_fire) begin
      // Channel 0 opens a frame: config is sampled here and frozen until the next frame.
      if (chan_q == '0) begin
        mode_d = act_mode_e'(cfg_mode);
        clip_d = cfg_clip;
      end
      chan_d = (io.s_last || chan_q == LAST_CH) ? '0 : chan_q + 1'b1;
      if (io.s_last != (chan_q == LAST_CH)) err_d = 1'b1;
    end
    if (frame_done) cnt_d = cnt_q + 16'd1;
  end

  motorb_act_func #(
    .W       (W),
    .LEAK_SH (LEAK_SH)
  ) u_func (
    .x    (s1_data_q),
    .mode (s1_mode_q),
    .clip (s1_clip_q),
    .y    (y)
  );

  always_ff @(posedge ap_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!ap_rst_n) begin
      chan_q     <= '0;
      mode_q     <= MODE_RELU;
      clip_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_clip_q  <= '0;
      s1_chan_q  <= '0;
      s1_mode_q  <= MODE_RELU;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
      m_chan_q   <= '0;
    end else begin
      chan_q <= chan_d;
      mode_q <= mode_d;
      clip_q <= clip_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      if (en) begin
        s1_valid_q <= io.s_valid;
        m_valid_q  <= s1_valid_q;
        if (io.s_valid) begin
          s1_data_q <= io.s_data;
          s1_last_q <= io.s_last;
          s1_chan_q <= chan_q;
          s1_mode_q <= mode_d;
          s1_clip_q <= clip_d;
        end
        if (s1_valid_q) begin
          m_data_q <= y;
          m_last_q <= s1_last_q;
          m_chan_q <= s1_chan_q;
        end
      end
    end
  end

endmodule

// File: doc/motorb_act_stream.md
MOTORB_ACT_STREAM -- requirements
Module: motorb_act_stream

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter W, 32, total data width of the signed fixed-point sample.
REQ-002 The block SHALL have parameter I, 8, integer bits including sign (fraction bits = W-I).
REQ-003 The block SHALL have parameter N_CH, 9, number of channels per frame (N_CH >= 2).
REQ-004 The block SHALL have parameter LEAK_SH, 3, arithmetic right-shift amount for the leaky slope.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port ap_clk, in, 1, the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port ap_rst_n, in, 1; reset is synchronous and active-low.
REQ-007 The block SHALL have the following ports:
- cfg_mode, in, 2: 0 = ReLU, 1 = leaky, 2 = clipped, 3 = bypass.
- cfg_clip, in, W: signed clip ceiling used in mode 2.
- s_valid / s_ready, in / out, 1 each: input handshake.
- s_data, in, W: signed input sample.
- s_last, in, 1: last channel of a frame.
- m_valid / m_ready, out / in, 1 each: output handshake.
- m_data, out, W: result.
- m_last, out, 1: last channel of a frame.
- m_chan, out, clog2(N_CH): channel index of m_data.
- frame_done, out, 1: one-cycle pulse.
- err_len, out, 1: sticky frame-length error.
- frame_cnt, out, 16: count of completed frames.

Function
REQ-008 Transfers SHALL occur only on cycles where valid and ready are both high, on either side.
REQ-009 The datapath SHALL be a two-stage register pipeline with a global enable, en = !m_valid || m_ready.
REQ-010 s_ready SHALL equal en (combinational); there are no bubbles, so a beat is accepted every cycle while m_ready is held high.
REQ-011 Latency SHALL be 2 cycles from input handshake to m_valid, with no stalls.
REQ-012 Output data, last and channel SHALL hold stable while m_valid && !m_ready.
REQ-013 Mode and clip SHALL be latched on the first accepted beat of each frame (channel index 0) and held for the whole frame; mid-frame cfg changes SHALL take effect only at the next frame.
REQ-014 Mode 0 SHALL output x if x > 0, else 0.
REQ-015 Mode 1 SHALL output x if x > 0, else x >>> LEAK_SH (arithmetic shift, rounding toward minus infinity).
REQ-016 Mode 2 SHALL output min(max(x,0), clip), where a negative clip is treated as 0.
REQ-017 Mode 3 SHALL output x unchanged.
REQ-018 All comparisons SHALL be signed and W-bit wide; no result SHALL overflow W bits.
REQ-019 The channel counter SHALL start at 0 and increment on each input handshake.
REQ-020 The channel counter SHALL return to 0 after a beat with s_last, or after the beat at index N_CH-1, whichever comes first.
REQ-021 err_len SHALL set when s_last arrives at index != N_CH-1, or when index N_CH-1 is accepted without s_last.
REQ-022 err_len SHALL clear only on reset.
REQ-023 m_chan SHALL carry the channel index of each beat, and m_last SHALL carry that beat's s_last.
REQ-024 frame_done SHALL pulse for exactly one cycle on each output handshake with m_last = 1.
REQ-025 frame_cnt SHALL increment on that same cycle and wrap from 0xFFFF to 0.
REQ-026 Simultaneous input and output handshakes SHALL both complete in the same cycle.

Reset
REQ-027 While ap_rst_n = 0 at a clock edge, the block SHALL set: m_valid = 0, m_data = 0, m_last = 0, m_chan = 0, frame_done = 0, err_len = 0, frame_cnt = 0, channel counter = 0, both stage valids = 0, and latched mode = 0.
REQ-028 s_ready SHALL be 0 while reset is asserted.
REQ-029 A reset mid-frame SHALL discard all in-flight beats; the next accepted beat after reset SHALL be channel 0.

Structure
REQ-030 A shared package SHALL hold the mode encoding constants (MODE_RELU, MODE_LEAKY, MODE_CLIP, MODE_BYPASS) and the default W, I and N_CH.
REQ-031 The per-sample combinational transfer function SHALL live in one sub-module, motorb_act_func (inputs x, mode, clip; output y), instantiated once between the stages.

Verification (Q8.24: 1.0 = 0x01000000)
REQ-032 Mode 0 test: frame {0x02000000, 0xFE000000, 0x00000000, 0x00000001, 0x80000000, ...} -> outputs {0x02000000, 0, 0, 0x00000001, 0}; the first output appears 2 cycles after the first input.
REQ-033 Mode 1 test: inputs 0xFE000000 (-2.0) and 0xFFFFFFFF -> outputs 0xFFC00000 (-0.25) and 0xFFFFFFFF.
REQ-034 Mode 2 test with clip = 0x06000000: inputs 0x07000000, 0x05000000, 0xFF000000 -> outputs 0x06000000, 0x05000000, 0; the same input 0x07000000 with clip = 0xFF000000 -> output 0.
REQ-035 Backpressure test: 9-beat frame with m_ready toggling on a random pattern -> no beat lost or duplicated, m_data stable while stalled, frame_done fires once, frame_cnt = 1.
REQ-036 Length-error and mode-latch test: s_last on the 5th beat -> err_len = 1 and the next beat has m_chan = 0; cfg_mode changed at beat 3 -> the whole frame is still processed in the old mode.
REQ-037 Reset test: assert ap_rst_n = 0 mid-frame -> all outputs return to 0 the next cycle, and the frame after release starts at m_chan = 0.
